seq_multiplier_nbit: RTL

SEQ_MULTIPLIER_NBIT -- requirements
Module: seq_multiplier_nbit

---
 rtl/seq_multiplier_nbit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier_nbit.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_nbit
// Brief   : Shift-add sequential N x N multiplier with signed/unsigned modes,
//           a fixed N+3 cycle latency and a 2N-bit registered product.
//           Optional macro SEQ_MUL_EARLY_EXIT_EN: leave STEP once the
//           multiplier register has emptied.
// Rev     : 1.0  initial release
// ============================================================================
module seq_multiplier_nbit #(
  parameter int N = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           mode_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int              C_CW   = $clog2(N) + 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(N - 1);
  localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    STEP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_mode;
  logic           r_sign;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [C_CW-1:0] r_count;
  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic           w_early_exit;

  // Negating the most negative value wraps to 2^(N-1), which is exact as unsigned.
  assign w_mag_a = (r_mode && r_a[N-1]) ? -r_a : r_a;
  assign w_mag_b = (r_mode && r_b[N-1]) ? -r_b : r_b;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign w_early_exit = (r_mplier == '0);
`else
  assign w_early_exit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = LOAD;
      end
      LOAD: w_next = STEP;
      STEP: if (w_early_exit || (r_count == C_LAST)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      product  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a    <= a;
          r_b    <= b;
          r_mode <= mode_signed;
        end
        LOAD: begin
          r_acc    <= '0;
          r_count  <= '0;
          r_mcand  <= {{N{1'b0}}, w_mag_a};
          r_mplier <= w_mag_b;
          r_sign   <= r_mode & (r_a[N-1] ^ r_b[N-1]);
        end
        STEP: if (!w_early_exit) begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + C_ONE;
        end
        FIX: product <= r_sign ? -r_acc : r_acc;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
